// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared word width and fetch FSM state encodings
package instr_fetch_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_PC = 3'd1,
    CAP    = 3'd2,
    MEM    = 3'd3,
    PUSH   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-two FIFO of fetched {instr, pc} entries with synchronous flush
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [QDEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  // A push into a full queue is accepted only when a pop frees the slot that same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM feeding a decode queue; FETCH_STATS_EN adds counters
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     PC_fetch,
  input  logic [WORD_W-1:0]        location,
  output logic                     PC_wb_tr,
  output logic signed [WORD_W-1:0] jump_inc,
  input  logic                     jump,
  output logic                     imem_req,
  output logic [WORD_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [WORD_W-1:0]        imem_data,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [WORD_W-1:0]        dec_instr,
  output logic [WORD_W-1:0]        dec_pc,
  output logic [WORD_W-1:0]        fetch_cnt,
  output logic [WORD_W-1:0]        flush_cnt
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [WORD_W-1:0]   data_q;
  logic                discard_q;
  logic                q_push;
  logic                q_pop;
  logic                q_full;
  logic                q_empty;
  logic                push_ok;
  logic [2*WORD_W-1:0] q_rdata;

  assign q_pop     = dec_ready && !q_empty;
  assign push_ok   = q_push && (!q_full || q_pop);
  assign dec_valid = !q_empty;
  assign dec_instr = q_rdata[2*WORD_W-1:WORD_W];
  assign dec_pc    = q_rdata[WORD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = REQ_PC;
      REQ_PC:  next_state = jump ? REQ_PC : CAP;
      CAP:     next_state = jump ? REQ_PC : MEM;
      // The memory handshake always completes; a redirect only marks the data as stale
      MEM:     if (imem_ack) next_state = (jump || discard_q) ? REQ_PC : PUSH;
      PUSH:    if (jump || push_ok) next_state = REQ_PC;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    PC_fetch = 1'b0;
    PC_wb_tr = 1'b0;
    jump_inc = '0;
    imem_req = 1'b0;
    q_push   = 1'b0;
    unique case (state)
      REQ_PC:  PC_fetch = !jump;
      CAP: begin
        PC_wb_tr = !jump;
        jump_inc = jump ? WORD_W'(0) : WORD_W'(1);
      end
      MEM:     imem_req = 1'b1;
      PUSH:    q_push = !jump;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr <= '0;
      data_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      if (state == CAP && !jump)  imem_addr <= location;
      if (state == MEM && imem_ack) data_q <= imem_data;
      discard_q <= (state == MEM) && !imem_ack && (discard_q || jump);
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .DW     (2 * WORD_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (jump),
    .push  (q_push),
    .pop   (q_pop),
    .wdata ({data_q, imem_addr}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push_ok) fetch_cnt <= fetch_cnt + 1'b1;
      if (jump)    flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch with PC and memory models
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     PC_fetch;
  logic [WORD_W-1:0]        location;
  logic                     PC_wb_tr;
  logic signed [WORD_W-1:0] jump_inc;
  logic                     jump;
  logic                     imem_req;
  logic [WORD_W-1:0]        imem_addr;
  logic                     imem_ack;
  logic [WORD_W-1:0]        imem_data;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [WORD_W-1:0]        dec_instr;
  logic [WORD_W-1:0]        dec_pc;
  logic [WORD_W-1:0]        fetch_cnt;
  logic [WORD_W-1:0]        flush_cnt;

`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  instr_fetch #(.QDEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .PC_fetch  (PC_fetch),
    .location  (location),
    .PC_wb_tr  (PC_wb_tr),
    .jump_inc  (jump_inc),
    .jump      (jump),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_instr (dec_instr),
    .dec_pc    (dec_pc),
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program counter model: loads the redirect target on jump, advances by jump_inc on PC_wb_tr
  logic [WORD_W-1:0] pc, start_pc, jump_target;
  assign location = pc;
  always @(posedge clk) begin
    if (rst)           pc <= start_pc;
    else if (jump)     pc <= jump_target;
    else if (PC_wb_tr) pc <= pc + jump_inc;
  end

  // Memory model: word = addr ^ A54A, ack after ack_delay waiting cycles
  int                ack_delay;
  int                wcnt;
  logic              mdl_ack, inj_ack;
  logic [WORD_W-1:0] mem_q;
  assign imem_ack  = mdl_ack | inj_ack;
  assign imem_data = mem_q;
  always @(posedge clk) begin
    if (rst) begin
      mdl_ack <= 1'b0;
      wcnt    <= 0;
      mem_q   <= '0;
    end else if (imem_req && !mdl_ack && wcnt >= ack_delay) begin
      mdl_ack <= 1'b1;
      mem_q   <= imem_addr ^ 16'hA54A;
      wcnt    <= 0;
    end else begin
      mdl_ack <= 1'b0;
      wcnt    <= (imem_req && !mdl_ack) ? wcnt + 1 : 0;
    end
  end

  int wb_cnt;
  int fetch_pulses;
  always @(negedge clk) begin
    if (rst) begin
      wb_cnt       = 0;
      fetch_pulses = 0;
    end else begin
      if (PC_wb_tr) wb_cnt++;
      if (PC_fetch) fetch_pulses++;
      check("jump_inc_rule", 32'(jump_inc), PC_wb_tr ? 32'd1 : 32'd0);
      check("no_strobe_on_jump", {31'd0, jump && (PC_fetch || PC_wb_tr)}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [WORD_W-1:0] s, input int d);
    rst       = 1'b1;
    start_pc  = s;
    ack_delay = d;
    jump      = 1'b0;
    inj_ack   = 1'b0;
    dec_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      samp();
      if (dec_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      samp();
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fetch(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      samp();
      if (PC_fetch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [WORD_W-1:0] start;
    int                delay;
    logic [WORD_W-1:0] exp_instr;
    logic [WORD_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit ok;
    bit seen;
    int k;

    vecs[0] = '{16'h0010, 2, 16'hA55A, 16'h0010};
    vecs[1] = '{16'h0000, 0, 16'hA54A, 16'h0000};
    vecs[2] = '{16'h1234, 1, 16'hB77E, 16'h1234};
    vecs[3] = '{16'hFFFF, 3, 16'h5AB5, 16'hFFFF};
    vecs[4] = '{16'h00FF, 5, 16'hA5B5, 16'h00FF};

    rst = 1'b1; start_pc = '0; jump_target = '0; ack_delay = 0;
    jump = 1'b0; inj_ack = 1'b0; dec_ready = 1'b0;
    step(); step();
    samp();
    check("reset_ctrl", {28'd0, PC_fetch, PC_wb_tr, imem_req, dec_valid}, 32'd0);
    check("reset_addr", 32'(imem_addr), 32'd0);
    check("reset_cnts", {fetch_cnt, flush_cnt}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].start, vecs[v].delay);
      wait_valid(60, ok);
      check($sformatf("v%0d_valid", v), 32'(ok), 32'd1);
      check($sformatf("v%0d_instr", v), 32'(dec_instr), 32'(vecs[v].exp_instr));
      check($sformatf("v%0d_pc", v), 32'(dec_pc), 32'(vecs[v].exp_pc));
      check($sformatf("v%0d_wb_pulses", v), 32'(wb_cnt), 32'd1);
    end

    // Back-pressure: queue fills, FSM parks in PUSH, then drains in order
    do_reset(16'h0100, 1);
    repeat (40) samp();
    check("fill_fetches", 32'(fetch_pulses), 32'd3);
    check("fill_valid", 32'(dec_valid), 32'd1);
    check("fill_head", 32'(dec_pc), 32'h0100);
    repeat (20) samp();
    check("stall_fetches", 32'(fetch_pulses), 32'd3);
    check("stall_head", 32'(dec_pc), 32'h0100);
    step();
    dec_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      samp();
      if (dec_valid) begin
        check($sformatf("drain%0d_pc", k), 32'(dec_pc), 32'(16'h0100 + k));
        check($sformatf("drain%0d_instr", k), 32'(dec_instr), 32'((16'h0100 + k) ^ 16'hA54A));
        k++;
      end
    end
    check("drain_count", 32'(k), 32'd4);

    // Jump with pop on a full queue, plus statistics
    do_reset(16'h0400, 1);
    repeat (40) samp();
    check("stats_pre_fetch", 32'(fetch_cnt), STATS ? 32'd2 : 32'd0);
    step();
    jump = 1'b1; jump_target = 16'h0500; dec_ready = 1'b1;
    step();
    jump = 1'b0;
    samp();
    check("jump_beats_pop", 32'(dec_valid), 32'd0);
    wait_valid(60, ok);
    check("post_jump_valid", 32'(ok), 32'd1);
    check("post_jump_pc", 32'(dec_pc), 32'h0500);
    check("stats_fetch", 32'(fetch_cnt), STATS ? 32'd3 : 32'd0);
    check("stats_flush", 32'(flush_cnt), STATS ? 32'd1 : 32'd0);

    // Jump during MEM: request held to ack, data dropped, refetch at target
    do_reset(16'h0600, 6);
    dec_ready = 1'b1;
    wait_req(30, ok);
    check("mem_req_seen", 32'(ok), 32'd1);
    step();
    jump = 1'b1; jump_target = 16'h0700;
    step();
    jump = 1'b0;
    samp();
    check("mem_req_held", 32'(imem_req), 32'd1);
    check("mem_addr_held", 32'(imem_addr), 32'h0600);
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dec_valid) seen = 1'b1;
      if (PC_fetch) begin
        ok = 1'b1;
        break;
      end
      samp();
    end
    check("mem_discard", 32'(seen), 32'd0);
    check("mem_refetch", 32'(ok), 32'd1);
    wait_valid(60, ok);
    check("mem_target_pc", 32'(dec_pc), 32'h0700);
    check("mem_target_instr", 32'(dec_instr), 32'hA24A);

    // Jump during CAP: no advance strobe, PC_fetch reissued
    do_reset(16'h0800, 1);
    dec_ready = 1'b1;
    wait_fetch(30, ok);
    check("cap_fetch_seen", 32'(ok), 32'd1);
    step();
    jump = 1'b1; jump_target = 16'h0900;
    samp();
    check("cap_no_wb", 32'(PC_wb_tr), 32'd0);
    step();
    jump = 1'b0;
    samp();
    check("cap_refetch", 32'(PC_fetch), 32'd1);
    check("cap_wb_count", 32'(wb_cnt), 32'd0);
    wait_valid(60, ok);
    check("cap_target_pc", 32'(dec_pc), 32'h0900);

    // Reset during an open memory handshake, then a stray late ack
    do_reset(16'h0A00, 8);
    wait_req(30, ok);
    check("rst_req_seen", 32'(ok), 32'd1);
    step();
    rst = 1'b1;
    step();
    samp();
    check("rst_mid_ctrl", {28'd0, PC_fetch, PC_wb_tr, imem_req, dec_valid}, 32'd0);
    check("rst_mid_data", {jump_inc, imem_addr}, 32'd0);
    check("rst_mid_cnts", {fetch_cnt, flush_cnt}, 32'd0);
    step();
    rst = 1'b0;
    step();
    inj_ack = 1'b1;
    step();
    inj_ack = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      samp();
      if (dec_valid) seen = 1'b1;
    end
    check("late_ack_ignored", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
